vga_pong_graph: RTL
===================

// Module: vga_pong_graph
// PURPOSE
//  Pixel generator downstream of the 640x480 VGA sync stage. Consumes pixel_x/pixel_y/video_on/p_tick
//  and raw syncs; draws left wall, player paddle and a bouncing ball; emits registered 12-bit RGB
//  with hsync/vsync re-aligned. All object motion updates once per frame on an internal refresh tick.
// PARAMETERS
//  WALL_X_L    32   wall left column;  WALL_X_R 35  wall right column
//  PAD_X_L     600  paddle left column; PAD_X_R 603 paddle right column
//  PAD_H       72   paddle height (rows);  PAD_V 4  paddle step per frame
//  BALL_SIZE   8    ball edge (pixels);    BALL_V 2 ball speed per frame, each axis
//  SERVE_FR    60   frames ball is held at centre before play
// PORTS
//  clk       in   1   system clock (2x pixel rate)
//  reset     in   1   synchronous, active-high
//  p_tick    in   1   pixel-enable, one clk in two
//  video_on  in   1   active display area
//  pixel_x   in   10  current column;  pixel_y  in  10  current row
//  hsync_in  in   1   raw hsync;       vsync_in in  1   raw vsync
//  btn_up    in   1   paddle up (level, pre-debounced); btn_down in 1 paddle down
//  rgb       out  12  {R4,G4,B4}, registered
//  hsync     out  1   hsync_in delayed 1 clk;  vsync  out  1  vsync_in delayed 1 clk
//  miss_cnt  out  4   balls missed, saturates at 15
// BEHAVIOUR
//  - Reset: rgb=0, hsync=vsync=0, miss_cnt=0, pad_y=204, ball=(316,236), dx=+V, dy=+V, state SERVE,
//    serve counter 0. Reset mid-frame restores all on next edge; no partial frame state survives.
//  - refr_tick = p_tick & pixel_x==0 & pixel_y==481: exactly one clk pulse per frame.
//  - Pixel path: latency 1 clk; rgb/hsync/vsync registered every clk (not gated by p_tick).
//    video_on=0 -> rgb=0. Priority wall(0x00F) > paddle(0x0F0) > ball(0xF00) > bg(0xFFF).
//    Ball not drawn in SERVE? No: drawn at centre in SERVE; hidden in MISS.
//  - Paddle (all states, on refr_tick): up only -> pad_y-=PAD_V if pad_y>=PAD_V;
//    down only -> pad_y+=PAD_V if pad_y+PAD_H-1+PAD_V<=479; both/neither -> hold.
//  - FSM (transitions on refr_tick only):
//    SERVE: ball at (316,236), dx=+V, dy=+V; cnt++; cnt==SERVE_FR-1 -> PLAY, cnt=0.
//    PLAY : direction updated first, then ball += new (dx,dy) same tick:
//           ball_y<=V -> dy=+V; ball_y+SIZE-1>=479-V -> dy=-V;
//           ball_x<=WALL_X_R+V -> dx=+V;
//           right edge in [PAD_X_L-V, PAD_X_L] and rows overlap paddle -> dx=-V;
//           ball_x>=640-BALL_SIZE (after move) -> MISS. No 10-bit wrap may occur.
//    MISS : miss_cnt++ (hold at 15); -> SERVE next refr_tick.
//  - Simultaneous top/bottom impossible; wall and paddle hit exclusive by geometry.
// CONFIGURATION
//  VGA_ROUND_BALL_EN defined: ball masked by 8x8 bitmap ROM (circle); pixel drawn only where
//    ROM[row][col]=1, row/col = pixel - ball origin (3 LSBs). Collision remains square-box.
//  Undefined: ball is solid BALL_SIZE square; ROM not instantiated.
// STRUCTURE
//  vga_pkg.vh: H_DISPLAY=640, V_DISPLAY=480, refresh row 481, colour constants, FSM state
//    encodings (SERVE=0, PLAY=1, MISS=2), centre coordinates.
//  Sub-module vga_ball_rom (8x8 comb bitmap lookup), instantiated only under VGA_ROUND_BALL_EN.
// TESTING
//  1 reset then free-run vga_sync -> rgb=0, miss_cnt=0; first frame ball drawn at (316..323,236..243).
//  2 pixel (33,100), video_on=1 -> rgb=0x00F one clk later; hsync/vsync equal inputs delayed 1 clk.
//  3 hold btn_up 60 frames from pad_y=204 -> pad_y stops at 0, never wraps; both btns -> no move.
//  4 SERVE_FR frames after reset -> PLAY; ball_y forced to 2 with dy=-V -> next tick dy=+V, y=4.
//  5 paddle out of path, ball reaches x>=632 -> MISS, miss_cnt 0->1, ball re-centred next frame.
//  6 assert reset mid-PLAY at row 300 -> all outputs/state to reset values next edge; 16+ misses -> 15.

Source files
------------

// File: rtl/vga_pong_graph_pkg.sv
// Shared geometry, colours and game-state encoding for the pong pixel generator.
// Used by both the plain build and the VGA_ROUND_BALL_EN build.
package vga_pong_graph_pkg;

    typedef logic [9:0]  coord_t;
    typedef logic [11:0] rgb_t;
    typedef logic [5:0]  serve_cnt_t;

    localparam coord_t H_DISPLAY = 10'd640;
    localparam coord_t V_DISPLAY = 10'd480;
    localparam coord_t REFR_ROW  = 10'd481;

    localparam coord_t WALL_X_L  = 10'd32;
    localparam coord_t WALL_X_R  = 10'd35;
    localparam coord_t PAD_X_L   = 10'd600;
    localparam coord_t PAD_X_R   = 10'd603;
    localparam coord_t PAD_H     = 10'd72;
    localparam coord_t PAD_V     = 10'd4;
    localparam coord_t BALL_SIZE = 10'd8;
    localparam coord_t BALL_V    = 10'd2;

    localparam coord_t PAD_Y_RST = 10'd204;
    localparam coord_t BALL_X_C  = 10'd316;
    localparam coord_t BALL_Y_C  = 10'd236;

    // Derived bounds, kept 10 bits wide so no comparison needs widening.
    localparam coord_t PAD_LAST    = PAD_H - 10'd1;
    localparam coord_t BALL_LAST   = BALL_SIZE - 10'd1;
    localparam coord_t PAD_Y_MAX   = V_DISPLAY - PAD_H - PAD_V;
    localparam coord_t Y_BOUNCE    = V_DISPLAY - 10'd1 - BALL_V;
    localparam coord_t WALL_BOUNCE = WALL_X_R + BALL_V;
    localparam coord_t PAD_HIT_LO  = PAD_X_L - BALL_V;
    localparam coord_t BALL_X_MISS = H_DISPLAY - BALL_SIZE;

    localparam serve_cnt_t SERVE_LAST = 6'd59;

    localparam rgb_t COL_WALL  = 12'h00F;
    localparam rgb_t COL_PAD   = 12'h0F0;
    localparam rgb_t COL_BALL  = 12'hF00;
    localparam rgb_t COL_BG    = 12'hFFF;
    localparam rgb_t COL_BLACK = 12'h000;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } game_state_e;

    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_pong_graph_if.sv
// Pixel-stream bundle between the VGA sync stage (master) and the pong pixel generator (slave).
interface vga_pong_graph_if;
    import vga_pong_graph_pkg::*;

    logic   p_tick;
    logic   video_on;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   hsync_in;
    logic   vsync_in;
    rgb_t   rgb;
    logic   hsync;
    logic   vsync;

    modport master (
        output p_tick, video_on, pixel_x, pixel_y, hsync_in, vsync_in,
        input  rgb, hsync, vsync
    );

    modport slave (
        input  p_tick, video_on, pixel_x, pixel_y, hsync_in, vsync_in,
        output rgb, hsync, vsync
    );

endinterface

// File: rtl/vga_pong_graph_ball_rom.sv
// 8x8 circular ball bitmap; only compiled when VGA_ROUND_BALL_EN is defined.
`ifdef VGA_ROUND_BALL_EN
module vga_ball_rom (
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pix
);

    logic [7:0] line;

    always_comb begin
        line = 8'h00;
        case (row)
            3'd0:    line = 8'b0011_1100;
            3'd1:    line = 8'b0111_1110;
            3'd6:    line = 8'b0111_1110;
            3'd7:    line = 8'b0011_1100;
            default: line = 8'b1111_1111;
        endcase
        pix = line[col];
    end

endmodule
`endif

// File: rtl/vga_pong_graph.sv
// Pong pixel generator: wall, paddle and bouncing ball, with per-frame motion and registered RGB.
// Define VGA_ROUND_BALL_EN to mask the ball with a round bitmap instead of a solid square.
module vga_pong_graph
    import vga_pong_graph_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    vga_pong_graph_if.slave vif,
    input  logic            btn_up,
    input  logic            btn_down,
    output logic [3:0]      miss_cnt
);

    game_state_e state_q, state_d;
    serve_cnt_t  serve_cnt_q, serve_cnt_d;
    coord_t      pad_y_q, pad_y_d;
    coord_t      ball_x_q, ball_x_d;
    coord_t      ball_y_q, ball_y_d;
    logic        dx_neg_q, dx_neg_d;
    logic        dy_neg_q, dy_neg_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    rgb_t        rgb_q, rgb_d;
    logic        hsync_q, vsync_q;

    logic   refr_tick;
    coord_t ball_r, ball_b, pad_b;
    logic   pad_rows_hit, dx_neg_new, dy_neg_new;
    coord_t ball_x_mv, ball_y_mv;
    logic   wall_on, pad_on, ball_box, ball_on;

    assign refr_tick = vif.p_tick && (vif.pixel_x == '0) && (vif.pixel_y == REFR_ROW);
    assign ball_r    = ball_x_q + BALL_LAST;
    assign ball_b    = ball_y_q + BALL_LAST;
    assign pad_b     = pad_y_q + PAD_LAST;

    always_comb begin
        pad_y_d = pad_y_q;
        if (refr_tick) begin
            if (btn_up && !btn_down && (pad_y_q >= PAD_V))
                pad_y_d = pad_y_q - PAD_V;
            else if (btn_down && !btn_up && (pad_y_q <= PAD_Y_MAX))
                pad_y_d = pad_y_q + PAD_V;
        end
    end

    // Bounce decisions use pre-tick positions; the move then applies the new direction.
    always_comb begin
        dy_neg_new = dy_neg_q;
        if (ball_y_q <= BALL_V)
            dy_neg_new = 1'b0;
        else if (ball_b >= Y_BOUNCE)
            dy_neg_new = 1'b1;

        pad_rows_hit = (ball_y_q <= pad_b) && (ball_b >= pad_y_q);
        dx_neg_new   = dx_neg_q;
        if (ball_x_q <= WALL_BOUNCE)
            dx_neg_new = 1'b0;
        else if (in_span(ball_r, PAD_HIT_LO, PAD_X_L) && pad_rows_hit)
            dx_neg_new = 1'b1;

        ball_x_mv = dx_neg_new ? (ball_x_q - BALL_V) : (ball_x_q + BALL_V);
        ball_y_mv = dy_neg_new ? (ball_y_q - BALL_V) : (ball_y_q + BALL_V);
    end

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_neg_d    = dx_neg_q;
        dy_neg_d    = dy_neg_q;
        miss_cnt_d  = miss_cnt_q;
        if (refr_tick) begin
            case (state_q)
                ST_SERVE: begin
                    ball_x_d = BALL_X_C;
                    ball_y_d = BALL_Y_C;
                    dx_neg_d = 1'b0;
                    dy_neg_d = 1'b0;
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d     = ST_PLAY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 6'd1;
                    end
                end
                ST_PLAY: begin
                    ball_x_d = ball_x_mv;
                    ball_y_d = ball_y_mv;
                    dx_neg_d = dx_neg_new;
                    dy_neg_d = dy_neg_new;
                    if (ball_x_mv >= BALL_X_MISS)
                        state_d = ST_MISS;
                end
                ST_MISS: begin
                    if (miss_cnt_q != 4'd15)
                        miss_cnt_d = miss_cnt_q + 4'd1;
                    ball_x_d    = BALL_X_C;
                    ball_y_d    = BALL_Y_C;
                    dx_neg_d    = 1'b0;
                    dy_neg_d    = 1'b0;
                    serve_cnt_d = '0;
                    state_d     = ST_SERVE;
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    assign wall_on  = in_span(vif.pixel_x, WALL_X_L, WALL_X_R);
    assign pad_on   = in_span(vif.pixel_x, PAD_X_L, PAD_X_R) && in_span(vif.pixel_y, pad_y_q, pad_b);
    assign ball_box = (state_q != ST_MISS) && in_span(vif.pixel_x, ball_x_q, ball_r)
                      && in_span(vif.pixel_y, ball_y_q, ball_b);

`ifdef VGA_ROUND_BALL_EN
    logic [2:0] rom_row, rom_col;
    logic       rom_pix;

    // Offsets modulo 8 are exact inside the ball box, so only the low bits are needed.
    assign rom_row = vif.pixel_y[2:0] - ball_y_q[2:0];
    assign rom_col = vif.pixel_x[2:0] - ball_x_q[2:0];

    vga_ball_rom u_ball_rom (
        .row (rom_row),
        .col (rom_col),
        .pix (rom_pix)
    );

    assign ball_on = ball_box && rom_pix;
`else
    assign ball_on = ball_box;
`endif

    always_comb begin
        rgb_d = COL_BLACK;
        if (vif.video_on) begin
            if (wall_on)
                rgb_d = COL_WALL;
            else if (pad_on)
                rgb_d = COL_PAD;
            else if (ball_on)
                rgb_d = COL_BALL;
            else
                rgb_d = COL_BG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SERVE;
            serve_cnt_q <= '0;
            pad_y_q     <= PAD_Y_RST;
            ball_x_q    <= BALL_X_C;
            ball_y_q    <= BALL_Y_C;
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            miss_cnt_q  <= '0;
            rgb_q       <= COL_BLACK;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            pad_y_q     <= pad_y_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            miss_cnt_q  <= miss_cnt_d;
            rgb_q       <= rgb_d;
            hsync_q     <= vif.hsync_in;
            vsync_q     <= vif.vsync_in;
        end
    end

    assign vif.rgb   = rgb_q;
    assign vif.hsync = hsync_q;
    assign vif.vsync = vsync_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
